// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults, counter types and window helper for the battleship display.
// Cell periods are kept here so the colour driver and quadrant logic agree with the raster.
package vga_timing_gen_pkg;

  localparam int CNT_W        = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int CELL_W       = 80;
  localparam int CELL_H       = 60;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  // Half-open window [lo, hi); int compare so hi may reach 1024 without truncation.
  function automatic logic in_window(input cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that delays the sync pair to match colour-driver latency.
// DEPTH=0 is a plain wire; every stage resets to the idle sync level.
module sync_delay_line #(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // NOTE: this array is reset on purpose: the VGA pins must show the idle sync
      // level immediately after reset, not whatever the stages held before.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: prescaler, pixel/line counters, registered row/line/enable,
// frame_start pulse and delayed hsync/vsync for the battleship display.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   CLK_DIV    = 4,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] current_row,
  output logic [CNT_W-1:0] current_line,
  output logic             enable,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync
);

  localparam int   H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam logic SYNC_IDLE  = ~SYNC_POL;

  logic [PW-1:0] presc_q, presc_d;
  cnt_t          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  cnt_t          row_q, row_d, line_q, line_d;
  logic          tick;
  logic          pixel_tick_q, pixel_tick_d;
  logic          enable_q, enable_d;
  logic          frame_start_q, frame_start_d;
  sync_t         sync_q, sync_d, sync_dly;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tick          = (presc_q == PRESC_LAST);
    presc_d       = tick ? '0 : presc_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    pixel_tick_d  = tick;
    frame_start_d = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // Outputs describe the counter state one clk earlier, then hold for the pixel.
    row_d         = h_cnt_q;
    line_d        = v_cnt_q;
    enable_d      = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    sync_d.hs     = in_window(h_cnt_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)
                    ? SYNC_POL : SYNC_IDLE;
    sync_d.vs     = in_window(v_cnt_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)
                    ? SYNC_POL : SYNC_IDLE;
  end

  // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc_q       <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_tick_q  <= 1'b0;
      row_q         <= '0;
      line_q        <= '0;
      enable_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_q        <= '{hs: SYNC_IDLE, vs: SYNC_IDLE};
    end else begin
      presc_q       <= presc_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_tick_q  <= pixel_tick_d;
      row_q         <= row_d;
      line_q        <= line_d;
      enable_q      <= enable_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  sync_delay_line #(
    .WIDTH    (2),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .d     (sync_q),
    .q     (sync_dly)
  );

  assign pixel_tick   = pixel_tick_q;
  assign current_row  = row_q;
  assign current_line = line_q;
  assign enable       = enable_q;
  assign frame_start  = frame_start_q;
  assign hsync        = sync_dly.hs;
  assign vsync        = sync_dly.vs;

endmodule
